alu_op_sequencer: RTL and testbench

Registered issue/capture stage that sits directly upstream of the 8-bit ALU (`alu`). It accepts one operation at a time over a valid/ready handshake and latches the operands and command. It drives the ALU's `a`, `b`, `command` and `out_enable` inputs, waits a fixed settle window, then samples the ALU's 16-bit `y` into a result register. The result is presented downstream with its own valid/ready handshake, plus zero and error flags.

---
 rtl/alu_op_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage in front of the 8-bit ALU: latches one operation, holds the
// ALU inputs for a settle window, then captures y and presents it with a handshake.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [3:0]       in_cmd,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_command,
    output logic             alu_out_enable,
    input  logic [15:0]      alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_y,
    output logic [3:0]       res_cmd,
    output logic             res_zero,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESULT
    } state_t;

    localparam logic [3:0] CMD_DIV     = 4'd5;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [3:0]       r_alu_cmd;
    logic [15:0]      r_res_y;
    logic [3:0]       r_res_cmd;
    logic             r_res_zero;
    logic             r_res_err;
    logic [CNT_W-1:0] r_op_count;

    logic w_accept;
    logic w_div_zero;
    logic w_settled;
    logic w_res_done;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_div_zero = (in_cmd == CMD_DIV) && (in_b == '0);
    assign w_settled  = (r_state == ISSUE) && (r_cnt == '0);
    assign w_res_done = (r_state == RESULT) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = w_div_zero ? RESULT : ISSUE;
                end
            end
            ISSUE: begin
                if (r_cnt == '0) begin
                    w_next = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready       = 1'b0;
        busy           = 1'b1;
        alu_out_enable = 1'b0;
        res_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ISSUE:   alu_out_enable = 1'b1;
            RESULT:  res_valid      = 1'b1;
            default: ;
        endcase
    end

    // Divide-by-zero is resolved at accept time; the ALU never sees that operation enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_cmd  <= '0;
            r_res_y    <= '0;
            r_res_cmd  <= '0;
            r_res_zero <= 1'b0;
            r_res_err  <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= in_a;
                r_alu_b   <= in_b;
                r_alu_cmd <= in_cmd;
                r_res_cmd <= in_cmd;
                r_cnt     <= SETTLE_LOAD;
                if (w_div_zero) begin
                    r_res_y    <= '1;
                    r_res_zero <= 1'b0;
                    r_res_err  <= 1'b1;
                end
            end else if (w_settled) begin
                r_res_y    <= alu_y;
                r_res_zero <= (alu_y == '0);
                r_res_err  <= 1'b0;
            end else if (r_state == ISSUE) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_res_done) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_command = r_alu_cmd;
    assign res_y       = r_res_y;
    assign res_cmd     = r_res_cmd;
    assign res_zero    = r_res_zero;
    assign res_err     = r_res_err;
    assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: two sequencers (settle 1 / 2-bit counter, settle 4 / 16-bit counter)
// each driving a behavioural ALU that only produces a valid y after the settle window.
module tb_alu_op_sequencer;

    localparam int unsigned S0  = 1;
    localparam int unsigned S1  = 4;
    localparam int unsigned CW0 = 2;
    localparam int unsigned CW1 = 16;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  cmd;
        logic        zero;
        logic        err;
        logic [31:0] rise;
        logic [31:0] oe;
    } exp_t;

    logic        clk;
    logic        rst_n       [2];
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic [7:0]  in_a        [2];
    logic [7:0]  in_b        [2];
    logic [3:0]  in_cmd      [2];
    logic [7:0]  alu_a       [2];
    logic [7:0]  alu_b       [2];
    logic [3:0]  alu_command [2];
    logic        alu_oe      [2];
    logic [15:0] alu_y       [2];
    logic        res_valid   [2];
    logic        res_ready   [2];
    logic [15:0] res_y       [2];
    logic [3:0]  res_cmd     [2];
    logic        res_zero    [2];
    logic        res_err     [2];
    logic        busy        [2];
    logic [15:0] op_count    [2];
    logic [CW0-1:0] oc0;
    logic [CW1-1:0] oc1;

    exp_t        sbq [2][$];
    int unsigned rr_mode [2];
    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    assign op_count[0] = 16'(oc0);
    assign op_count[1] = oc1;

    alu_op_sequencer #(.SETTLE_CYCLES(S0), .CNT_W(CW0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_cmd(in_cmd[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_command(alu_command[0]),
        .alu_out_enable(alu_oe[0]), .alu_y(alu_y[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_y(res_y[0]),
        .res_cmd(res_cmd[0]), .res_zero(res_zero[0]), .res_err(res_err[0]),
        .busy(busy[0]), .op_count(oc0)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(S1), .CNT_W(CW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_cmd(in_cmd[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_command(alu_command[1]),
        .alu_out_enable(alu_oe[1]), .alu_y(alu_y[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_y(res_y[1]),
        .res_cmd(res_cmd[1]), .res_zero(res_zero[1]), .res_err(res_err[1]),
        .busy(busy[1]), .op_count(oc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned settle_of(input int unsigned i);
        return (i == 0) ? S0 : S1;
    endfunction

    function automatic logic [15:0] cnt_mask(input int unsigned i);
        return (i == 0) ? 16'h0003 : 16'hFFFF;
    endfunction

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        case (c)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return 16'(a & b);
            4'd4:    return 16'(a | b);
            4'd5:    return (b == 8'd0) ? 16'h0BAD : 16'(a / b);
            4'd6:    return 16'(a ^ b);
            4'd7:    return 16'(~a);
            4'd15:   return 16'(a);
            default: return {a, b} ^ {12'h0, c};
        endcase
    endfunction

    function automatic void chk(input int unsigned i, input string name,
                                input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%h exp=%h", name, i, $time, got, exp);
        end
    endfunction

    // Caller is at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input int unsigned i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c, output int unsigned acc);
        exp_t        e;
        int unsigned guard;
        logic        dz;
        in_valid[i] = 1'b1;
        in_a[i]     = a;
        in_b[i]     = b;
        in_cmd[i]   = c;
        guard       = 0;
        @(negedge clk);
        while (!in_ready[i] && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        acc = cyc + 1;
        if (!in_ready[i]) begin
            chk(i, "accept_timeout", 32'(in_ready[i]), 32'd1);
        end else begin
            dz     = (c == 4'd5) && (b == 8'd0);
            e.y    = dz ? 16'hFFFF : alu_f(a, b, c);
            e.cmd  = c;
            e.zero = (e.y == 16'h0);
            e.err  = dz;
            e.rise = dz ? acc : acc + settle_of(i);
            e.oe   = dz ? 32'd0 : settle_of(i);
            sbq[i].push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic drain(input int unsigned i);
        int unsigned guard;
        guard = 0;
        while (sbq[i].size() != 0 && guard < 500) begin
            guard++;
            @(posedge clk);
            #1;
        end
        chk(i, "drain_timeout", sbq[i].size(), 32'd0);
    endtask

    task automatic check_reset_state(input int unsigned i);
        chk(i, "rst_in_ready",  32'(in_ready[i]),    32'd1);
        chk(i, "rst_busy",      32'(busy[i]),        32'd0);
        chk(i, "rst_res_valid", 32'(res_valid[i]),   32'd0);
        chk(i, "rst_alu_oe",    32'(alu_oe[i]),      32'd0);
        chk(i, "rst_alu_a",     32'(alu_a[i]),       32'd0);
        chk(i, "rst_alu_b",     32'(alu_b[i]),       32'd0);
        chk(i, "rst_alu_cmd",   32'(alu_command[i]), 32'd0);
        chk(i, "rst_res_y",     32'(res_y[i]),       32'd0);
        chk(i, "rst_res_cmd",   32'(res_cmd[i]),     32'd0);
        chk(i, "rst_res_flags", 32'({res_zero[i], res_err[i]}), 32'd0);
        chk(i, "rst_op_count",  32'(op_count[i]),    32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            if (rr_mode[g] == 0)      res_ready[g] = 1'b1;
            else if (rr_mode[g] == 1) res_ready[g] = ($urandom_range(0, 3) != 0);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_env
        int unsigned oe_run = 0;
        int unsigned oe_seen = 0;
        logic [15:0] cnt_model = '0;
        logic        prev_v = 1'b0;
        exp_t        e;

        // ALU model: y is only meaningful once out_enable has been high for the settle window.
        always @(posedge clk) oe_run <= alu_oe[g] ? oe_run + 1 : 0;
        assign alu_y[g] = (alu_oe[g] && (oe_run + 1 >= settle_of(g)))
                          ? alu_f(alu_a[g], alu_b[g], alu_command[g])
                          : (16'hDEAD ^ 16'(oe_run));

        always @(negedge clk) begin
            if (!rst_n[g]) begin
                cnt_model = '0;
                oe_seen   = 0;
                prev_v    = 1'b0;
                sbq[g].delete();
            end else begin
                chk(g, "op_count", 32'(op_count[g]), 32'(cnt_model));
                chk(g, "busy_vs_ready", 32'(busy[g]), 32'(!in_ready[g]));
                if (alu_oe[g]) oe_seen++;
                if (res_valid[g]) begin
                    if (sbq[g].size() == 0) begin
                        chk(g, "unexpected_res_valid", 32'(res_valid[g]), 32'd0);
                    end else begin
                        e = sbq[g][0];
                        if (!prev_v) begin
                            chk(g, "res_valid_rise_edge", cyc, e.rise);
                            chk(g, "alu_oe_cycles", oe_seen, e.oe);
                            oe_seen = 0;
                        end
                        chk(g, "res_y",    32'(res_y[g]),    32'(e.y));
                        chk(g, "res_cmd",  32'(res_cmd[g]),  32'(e.cmd));
                        chk(g, "res_zero", 32'(res_zero[g]), 32'(e.zero));
                        chk(g, "res_err",  32'(res_err[g]),  32'(e.err));
                        chk(g, "in_ready_in_result", 32'(in_ready[g]), 32'd0);
                        chk(g, "alu_oe_in_result",   32'(alu_oe[g]),   32'd0);
                        if (res_ready[g]) begin
                            void'(sbq[g].pop_front());
                            cnt_model = (cnt_model + 16'd1) & cnt_mask(g);
                        end
                    end
                end
                prev_v = res_valid[g];
            end
        end
    end

    initial begin
        int unsigned acc1, acc2, acc;
        int unsigned guard;
        logic [3:0]  c;
        logic [7:0]  a, b;
        for (int g = 0; g < 2; g++) begin
            rst_n[g]     = 1'b0;
            in_valid[g]  = 1'b0;
            in_a[g]      = '0;
            in_b[g]      = '0;
            in_cmd[g]    = '0;
            res_ready[g] = 1'b0;
            rr_mode[g]   = 2;
        end
        repeat (2) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        @(posedge clk);
        #1;
        rst_n[0]   = 1'b1;
        rst_n[1]   = 1'b1;
        rr_mode[0] = 0;
        rr_mode[1] = 0;

        // Directed sequence on the settle-1 instance; 5 ops wrap the 2-bit counter.
        issue(0, 8'd25, 8'd17, 4'd0, acc);
        issue(0, 8'd15, 8'd15, 4'd2, acc1);
        issue(0, 8'd10, 8'd10, 4'd1, acc2);
        chk(0, "back_to_back_gap", acc2 - acc1, 32'd3);
        issue(0, 8'd20, 8'd0,  4'd5, acc);
        issue(0, 8'd20, 8'd10, 4'd5, acc);
        drain(0);
        repeat (2) @(posedge clk);
        #1;
        chk(0, "op_count_after_5", 32'(op_count[0]), 32'd1);

        // Backpressure on the settle-4 instance.
        rr_mode[1]   = 2;
        res_ready[1] = 1'b0;
        issue(1, 8'd7, 8'd6, 4'd2, acc);
        guard = 0;
        @(negedge clk);
        while (!res_valid[1] && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        chk(1, "stall_res_valid_seen", 32'(res_valid[1]), 32'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        res_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        chk(1, "post_handshake_res_valid", 32'(res_valid[1]), 32'd0);
        chk(1, "post_handshake_in_ready",  32'(in_ready[1]),  32'd1);
        rr_mode[1] = 0;

        // Random traffic with random backpressure.
        for (int g = 0; g < 2; g++) begin
            rr_mode[g] = 1;
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                c = 4'($urandom_range(0, 15));
                a = 8'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                issue(g, a, b, c, acc);
            end
            rr_mode[g] = 0;
            drain(g);
        end

        // Asynchronous reset in the middle of the settle window.
        issue(1, 8'd100, 8'd55, 4'd0, acc);
        @(posedge clk);
        #2;
        chk(1, "alu_oe_before_reset", 32'(alu_oe[1]), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        check_reset_state(1);
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk(1, "no_res_valid_after_reset", 32'(res_valid[1]), 32'd0);
        end
        chk(1, "in_ready_after_reset", 32'(in_ready[1]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
